// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM arbiter slice.
//   - default widths for row/column address, bank address and data bus
//   - arbiter state codes (one 3-bit state register in sdram_arbit)
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
// Configuration macro used by the files importing this package:
//   SDRAM_ARB_RR_EN  - alternate write/read when both are pending.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BA_W_DEF   = 2;
    localparam int DQ_W_DEF   = 16;

    // Arbiter state encoding.
    typedef logic [2:0] arb_state_t;
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    // SDRAM commands, bit3 = cs_n, bit2 = ras_n, bit1 = cas_n, bit0 = we_n.
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // True for the three states that own the SDRAM bus on behalf of a stage.
    function automatic logic is_grant_state(input logic [2:0] st);
        return (st == ST_AREF) || (st == ST_WRITE) || (st == ST_READ);
    endfunction

endpackage

// File: rtl/sdram_arb_grant.sv
// -----------------------------------------------------------------------------
// sdram_arb_grant
// Combinational next-grant selection used while the arbiter sits in ARBIT.
// Refresh always wins. Between write and read:
//   SDRAM_ARB_RR_EN undefined : write beats read.
//   SDRAM_ARB_RR_EN defined   : when both are pending, serve the one that was
//                               not served last (last_wr = 1 -> read wins).
// Ports
//   aref_req, wr_req, rd_req  in   pending requests
//   last_wr                   in   last served was write (RR build only)
//   grant_state               out  state to enter next cycle (ARBIT = none)
// -----------------------------------------------------------------------------
module sdram_arb_grant
    import sdram_pkg::*;
(
    input  logic       aref_req,
    input  logic       wr_req,
    input  logic       rd_req,
`ifdef SDRAM_ARB_RR_EN
    input  logic       last_wr,
`endif
    output logic [2:0] grant_state
);

    always_comb begin
        grant_state = ST_ARBIT;
        if (aref_req) begin
            grant_state = ST_AREF;
        end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARB_RR_EN
            grant_state = last_wr ? ST_READ : ST_WRITE;
`else
            grant_state = ST_WRITE;
`endif
        end else if (wr_req) begin
            grant_state = ST_WRITE;
        end else if (rd_req) begin
            grant_state = ST_READ;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Arbitrates the SDRAM command bus between the init, auto-refresh, write and
// read stages and multiplexes the owning stage's command/address/data onto the
// SDRAM pins.
//
// Grant handshake: a stage holds *_req until it sees its *_en; *_en is a
// registered grant that rises in the cycle the FSM enters the stage's state and
// stays high until the stage pulses *_end, which the arbiter samples on the
// next rising edge, returning to ARBIT and dropping *_en in that same cycle.
// Grants are non-preemptive and at least one ARBIT cycle separates them.
// *_end seen outside the owning state is ignored.
//
// Configuration macro: SDRAM_ARB_RR_EN (write/read alternation, see
// sdram_arb_grant). Default build uses fixed write-over-read priority.
//
// Ports
//   sys_clk, sys_rst                      clock, synchronous active-high reset
//   init_end, init_cmd/ba/addr            init stage done + command bus
//   aref_req/end, aref_cmd/ba/addr        refresh stage
//   wr_req/end, wr_cmd/ba/addr, wr_dq,
//   wr_dq_oe                              write stage
//   rd_req/end, rd_cmd/ba/addr            read stage
//   aref_en, wr_en, rd_en                 grants
//   sdram_cke .. sdram_dq_oe              SDRAM pins
//   arb_state                             current FSM state (debug)
// -----------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,

    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,

    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              wr_dq_oe,

    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,

    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe,

    output logic [2:0]        arb_state
);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [2:0]        grant_state;
    logic [3:0]        cmd;

`ifdef SDRAM_ARB_RR_EN
    // 1 = write was the last stage granted; reset to "read" so write goes first.
    logic              last_wr;
`endif

    sdram_arb_grant u_grant (
        .aref_req    (aref_req),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
`ifdef SDRAM_ARB_RR_EN
        .last_wr     (last_wr),
`endif
        .grant_state (grant_state)
    );

    // Next-state logic. Each grant state only listens to its own *_end.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  if (init_end) next_state = ST_ARBIT;
            ST_ARBIT: next_state = grant_state;
            ST_AREF:  if (aref_end) next_state = ST_ARBIT;
            ST_WRITE: if (wr_end)   next_state = ST_ARBIT;
            ST_READ:  if (rd_end)   next_state = ST_ARBIT;
            default:  next_state = ST_INIT;
        endcase
    end

    // Grants are registered from next_state so they line up exactly with the
    // state register: high in every cycle the FSM sits in the owning state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= ST_INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            state   <= next_state;
            aref_en <= (next_state == ST_AREF);
            wr_en   <= (next_state == ST_WRITE);
            rd_en   <= (next_state == ST_READ);
        end
    end

`ifdef SDRAM_ARB_RR_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_wr <= 1'b0;
        end else if (state == ST_ARBIT && next_state == ST_WRITE) begin
            last_wr <= 1'b1;
        end else if (state == ST_ARBIT && next_state == ST_READ) begin
            last_wr <= 1'b0;
        end
    end
`endif

    // Command mux driven purely by state; ARBIT (and any unused code) idles
    // the bus with NOP, bank 0, address 0.
    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = '0;
        sdram_addr = '0;
        case (state)
            ST_INIT: begin
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd        = CMD_NOP;
                sdram_ba   = '0;
                sdram_addr = '0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    // Only the write stage may drive the data bus.
    assign sdram_dq_out = (state == ST_WRITE) ? wr_dq    : '0;
    assign sdram_dq_oe  = (state == ST_WRITE) ? wr_dq_oe : 1'b0;

    assign sdram_cke = 1'b1;
    assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
// Directed bench for sdram_arbit. The driver advances one clock at a time,
// applies inputs just after the rising edge and pushes the hand-computed output
// vector for that cycle into exp_q; a monitor on the falling edge pops and
// compares against the DUT outputs.
// Expected vector: {state, aref_en, wr_en, rd_en, cmd, ba, addr, dq, oe, cke}.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;
    import sdram_pkg::*;

    localparam int EXP_W = 3 + 3 + 4 + 2 + 13 + 16 + 1 + 1;

    // Fixed stage buses (distinct values so a wrong mux selection is visible).
    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [1:0]  INIT_BA   = 2'b01;
    localparam logic [12:0] INIT_ADDR = 13'h0400;
    localparam logic [3:0]  AREF_CMD  = 4'b0001;
    localparam logic [1:0]  AREF_BA   = 2'b10;
    localparam logic [12:0] AREF_ADDR = 13'h0005;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [1:0]  WR_BA     = 2'b11;
    localparam logic [12:0] WR_ADDR   = 13'h0123;
    localparam logic [15:0] WR_DQ     = 16'hA5A5;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [1:0]  RD_BA     = 2'b01;
    localparam logic [12:0] RD_ADDR   = 13'h00AB;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #3 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic rst_d = 1'b0;
    always @(posedge sys_clk) rst_d <= sys_rst;

    // ---------------- DUT ----------------
    logic        init_end = 1'b0;
    logic        aref_req = 1'b0, aref_end = 1'b0;
    logic        wr_req = 1'b0, wr_end = 1'b0, wr_dq_oe = 1'b0;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [2:0]  arb_state;

    sdram_arbit dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .init_end     (init_end),
        .init_cmd     (INIT_CMD),
        .init_ba      (INIT_BA),
        .init_addr    (INIT_ADDR),
        .aref_req     (aref_req),
        .aref_end     (aref_end),
        .aref_cmd     (AREF_CMD),
        .aref_ba      (AREF_BA),
        .aref_addr    (AREF_ADDR),
        .wr_req       (wr_req),
        .wr_end       (wr_end),
        .wr_cmd       (WR_CMD),
        .wr_ba        (WR_BA),
        .wr_addr      (WR_ADDR),
        .wr_dq        (WR_DQ),
        .wr_dq_oe     (wr_dq_oe),
        .rd_req       (rd_req),
        .rd_end       (rd_end),
        .rd_cmd       (RD_CMD),
        .rd_ba        (RD_BA),
        .rd_addr      (RD_ADDR),
        .aref_en      (aref_en),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .sdram_cke    (sdram_cke),
        .sdram_cs_n   (sdram_cs_n),
        .sdram_ras_n  (sdram_ras_n),
        .sdram_cas_n  (sdram_cas_n),
        .sdram_we_n   (sdram_we_n),
        .sdram_ba     (sdram_ba),
        .sdram_addr   (sdram_addr),
        .sdram_dq_out (sdram_dq_out),
        .sdram_dq_oe  (sdram_dq_oe),
        .arb_state    (arb_state)
    );

    // ---------------- expected-vector builders ----------------
    function automatic logic [EXP_W-1:0] f_init();
        return {ST_INIT, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR, 16'h0, 1'b0, 1'b1};
    endfunction
    function automatic logic [EXP_W-1:0] f_arbit();
        return {ST_ARBIT, 3'b000, 4'b0111, 2'b00, 13'h0, 16'h0, 1'b0, 1'b1};
    endfunction
    function automatic logic [EXP_W-1:0] f_aref();
        return {ST_AREF, 3'b100, AREF_CMD, AREF_BA, AREF_ADDR, 16'h0, 1'b0, 1'b1};
    endfunction
    function automatic logic [EXP_W-1:0] f_wr(input logic oe);
        return {ST_WRITE, 3'b010, WR_CMD, WR_BA, WR_ADDR, WR_DQ, oe, 1'b1};
    endfunction
    function automatic logic [EXP_W-1:0] f_rd();
        return {ST_READ, 3'b001, RD_CMD, RD_BA, RD_ADDR, 16'h0, 1'b0, 1'b1};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               total  = 0;
    int               bad    = 0;
    int               pushed = 0;

    always @(negedge sys_clk) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        string            nm;
        if (rst_d) begin
            if (arb_state !== ST_INIT || aref_en !== 1'b0 || wr_en !== 1'b0 ||
                rd_en !== 1'b0 || sdram_dq_oe !== 1'b0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d state=%0d en=%b%b%b oe=%b",
                         cyc, arb_state, aref_en, wr_en, rd_en, sdram_dq_oe);
            end
        end
        if ((32'(aref_en) + 32'(wr_en) + 32'(rd_en)) > 1) begin
            bad++;
            $display("FAIL grant_onehot cyc=%0d en=%b%b%b", cyc, aref_en, wr_en, rd_en);
        end
        if (exp_q.size() != 0) begin
            got  = {arb_state, aref_en, wr_en, rd_en,
                    sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                    sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe, sdram_cke};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input logic [EXP_W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        pushed++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic rr;
        logic is_rd;
`ifdef SDRAM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        // Reset held for cycles 1..5, init_end seen at the edge of cycle 11.
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) sys_rst = 1'b0;
            chk(f_init(), "reset_init");
        end
        for (int k = 6; k <= 10; k++) begin
            tick();
            if (k == 10) init_end = 1'b1;
            chk(f_init(), "init_wait");
        end
        tick(); chk(f_arbit(), "init_to_arbit");

        // Stray *_end pulses while idle in ARBIT.
        tick(); rd_end = 1'b1; chk(f_arbit(), "arbit_idle");
        tick(); rd_end = 1'b0; wr_end = 1'b1; aref_end = 1'b1;
        chk(f_arbit(), "stray_rd_end");
        tick(); wr_end = 1'b0; aref_end = 1'b0;
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        chk(f_arbit(), "stray_wr_aref_end");

        // All three requests together: refresh first, then write.
        tick(); aref_req = 1'b0; wr_end = 1'b1; rd_end = 1'b1;
        chk(f_aref(), "aref_first");
        tick(); wr_end = 1'b0; rd_end = 1'b0; chk(f_aref(), "aref_ignores_wr_rd_end");
        tick(); aref_end = 1'b1; chk(f_aref(), "aref_hold");
        tick(); aref_end = 1'b0; wr_dq_oe = 1'b1; chk(f_arbit(), "aref_done_arbit");
        tick(); wr_req = 1'b0; rd_req = 1'b0; chk(f_wr(1'b1), "write_after_aref");

        // Eight-cycle write burst, refresh request arriving mid-burst.
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 3) aref_req = 1'b1;
            if (i == 4) wr_dq_oe = 1'b0;
            if (i == 7) wr_end = 1'b1;
            chk(f_wr(i < 4), "write_burst");
        end
        tick(); wr_end = 1'b0; wr_dq_oe = 1'b1; chk(f_arbit(), "write_end_arbit");
        tick(); aref_req = 1'b0; chk(f_aref(), "aref_after_write");
        tick(); aref_end = 1'b1; chk(f_aref(), "aref_hold2");
        tick(); aref_end = 1'b0; rd_req = 1'b1; chk(f_arbit(), "arbit_before_read");

        // Reset in the middle of a read; stray rd_end afterwards.
        tick(); rd_req = 1'b0; chk(f_rd(), "read_grant");
        tick(); sys_rst = 1'b1; chk(f_rd(), "read_hold");
        tick(); sys_rst = 1'b0; init_end = 1'b0; rd_end = 1'b1;
        chk(f_init(), "reset_aborts_read");
        tick(); rd_end = 1'b0; chk(f_init(), "stray_rd_end_in_init");
        tick(); init_end = 1'b1; chk(f_init(), "init_wait2");
        tick(); wr_req = 1'b1; rd_req = 1'b1; chk(f_arbit(), "init_done2");

        // Write and read both held: W,R,W,R with alternation, else W,W,W,W.
        for (int g = 0; g < 4; g++) begin
            is_rd = rr && (g % 2 == 1);
            tick(); chk(is_rd ? f_rd() : f_wr(1'b1), "both_grant");
            tick();
            if (is_rd) rd_end = 1'b1;
            else       wr_end = 1'b1;
            chk(is_rd ? f_rd() : f_wr(1'b1), "both_hold");
            tick(); rd_end = 1'b0; wr_end = 1'b0;
            if (g == 3) begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            chk(f_arbit(), "both_gap");
        end
        tick(); chk(f_arbit(), "final_idle");

        @(negedge sys_clk);
        #1;
        if (exp_q.size() != 0 || total != pushed) begin
            bad++;
            $display("FAIL expired_wait: %0d expected vectors never compared (total=%0d pushed=%0d)",
                     exp_q.size(), total, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad == 0) $display("PASS");
        else          $display("FAIL");
        $finish;
    end

endmodule
